// File: rtl/kernel_loader.sv
// Kernel loader: fetches one K*K weight kernel from weight memory into a shadow
// buffer, then commits it to kernel_out in a single edge.
module kernel_loader #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int OUT_CH = 8,
   parameter int IN_CH  = 1,
   parameter int ADDR_W = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req,
   input  logic [3:0]                 och,
   input  logic [3:0]                 ich,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [K*K*DATA_W-1:0]      kernel_out,
   output logic                       busy,
   output logic                       done,
   output logic                       valid,
   output logic                       err,
   output logic [1:0]                 dbg_state
);

   localparam int T     = K * K;
   localparam int CNT_W = $clog2(T + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   // Handshake: req is sampled only in IDLE; a load runs to completion and is
   // signalled by a one-cycle done; busy covers every non-IDLE cycle.
   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [T*DATA_W-1:0]     kernel_q, kernel_d;
   logic                    valid_q, valid_d;
   logic                    err_q;
   logic                    rd_pend_q;
   logic [CNT_W-1:0]        rd_idx_q;
   logic [DATA_W-1:0]       shadow_q [T];
   logic                    in_range;
   logic                    accept;
   logic                    reject;
   int                      base_calc;

   assign in_range  = (int'(och) < OUT_CH) && (int'(ich) < IN_CH);
   assign accept    = (state_q == S_IDLE) && req && in_range;
   assign reject    = (state_q == S_IDLE) && req && !in_range;
   assign base_calc = (int'(och) * IN_CH + int'(ich)) * T;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               base_d  = ADDR_W'(base_calc);
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(T - 1)) state_d = S_DRAIN;
         end
         S_DRAIN:  state_d = S_COMMIT;
         default:  state_d = S_IDLE;
      endcase
   end

   assign mem_rd_en = (state_q == S_FETCH);
   assign mem_addr  = mem_rd_en ? (base_q + ADDR_W'(cnt_q)) : '0;

   // The last word is still on mem_rdata during DRAIN, so it bypasses the
   // shadow buffer; this makes the new kernel visible in the COMMIT cycle.
   always_comb begin
      kernel_d = kernel_q;
      valid_d  = valid_q;
      if (state_q == S_DRAIN) begin
         for (int i = 0; i < T; i++) begin
            kernel_d[i*DATA_W +: DATA_W] = (i == T - 1) ? mem_rdata : shadow_q[i];
         end
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         base_q    <= '0;
         kernel_q  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= '0;
         for (int i = 0; i < T; i++) shadow_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         kernel_q  <= kernel_d;
         valid_q   <= valid_d;
         err_q     <= reject;
         rd_pend_q <= mem_rd_en;
         rd_idx_q  <= cnt_q;
         for (int i = 0; i < T; i++) begin
            if (rd_pend_q && (rd_idx_q == CNT_W'(i))) shadow_q[i] <= mem_rdata;
         end
      end
   end

   assign kernel_out = kernel_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_COMMIT);
   assign valid      = valid_q;
   assign err        = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: directed vector table of load/reject requests plus
// hand-written sequences for held req, mid-load reset and IN_CH=2 addressing.
module tb_kernel_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [3:0]  och, ich;
   logic        rd_en;
   logic [9:0]  addr;
   logic [7:0]  rdata;
   logic [71:0] kout;
   logic        busy, done, valid, err;
   logic [1:0]  dstate;

   logic        req2;
   logic [3:0]  och2, ich2;
   logic        rd_en2;
   logic [9:0]  addr2;
   logic [7:0]  rdata2;
   logic [71:0] kout2;
   logic        busy2, done2, valid2, err2;
   logic [1:0]  dstate2;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [9:0]  exp_q[$];
   logic [71:0] cur_kernel;
   logic        cur_valid;

   kernel_loader u_dut (
      .clk(clk), .rst(rst), .req(req), .och(och), .ich(ich),
      .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
      .kernel_out(kout), .busy(busy), .done(done), .valid(valid),
      .err(err), .dbg_state(dstate)
   );

   kernel_loader #(.IN_CH(2)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .och(och2), .ich(ich2),
      .mem_rd_en(rd_en2), .mem_addr(addr2), .mem_rdata(rdata2),
      .kernel_out(kout2), .busy(busy2), .done(done2), .valid(valid2),
      .err(err2), .dbg_state(dstate2)
   );

   always #5 clk = ~clk;

   // Weight memory models: word n holds n, one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en)  rdata  <= addr[7:0];
      if (rd_en2) rdata2 <= addr2[7:0];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] mk_kernel(input int base);
      logic [71:0] k;
      for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'(base + i);
      return k;
   endfunction

   task automatic do_load(input int o, input int i, input int base);
      @(negedge clk);
      req = 1'b1; och = 4'(o); ich = 4'(i);
      for (int j = 0; j < 9; j++) exp_q.push_back(10'(base + j));
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (c <= 9) begin
            check("load_rd_en", rd_en, 1'b1);
            check("load_addr", addr, exp_q.pop_front());
         end else begin
            check("idle_rd_en", rd_en, 1'b0);
            check("idle_addr", addr, 10'd0);
         end
         if (c <= 10) begin
            check("kernel_hold", kout, cur_kernel);
            check("done_low", done, 1'b0);
         end
         if (c == 11) begin
            cur_kernel = mk_kernel(base);
            cur_valid  = 1'b1;
            check("done_pulse", done, 1'b1);
            check("kernel_new", kout, cur_kernel);
            check("valid_set", valid, 1'b1);
         end
         check("load_busy", busy, (c <= 11) ? 1'b1 : 1'b0);
         check("load_err", err, 1'b0);
      end
      check("exp_q_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic do_reject(input int o, input int i);
      @(negedge clk);
      req = 1'b1; och = 4'(o); ich = 4'(i);
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("rej_err", err, 1'b1);
      check("rej_rd_en", rd_en, 1'b0);
      check("rej_busy", busy, 1'b0);
      check("rej_kernel", kout, cur_kernel);
      check("rej_valid", valid, cur_valid);
      @(negedge clk);
      check("rej_err_clear", err, 1'b0);
      check("rej_rd_en2", rd_en, 1'b0);
   endtask

   typedef struct {
      int o;
      int i;
      bit rej;
      int base;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{o: 2,  i: 0, rej: 1'b0, base: 18};
      vecs[1] = '{o: 8,  i: 0, rej: 1'b1, base: 0};
      vecs[2] = '{o: 0,  i: 0, rej: 1'b0, base: 0};
      vecs[3] = '{o: 7,  i: 0, rej: 1'b0, base: 63};
      vecs[4] = '{o: 15, i: 3, rej: 1'b1, base: 0};
      vecs[5] = '{o: 0,  i: 1, rej: 1'b1, base: 0};
      vecs[6] = '{o: 1,  i: 0, rej: 1'b0, base: 9};

      rst = 1'b0; req = 1'b0; och = '0; ich = '0;
      req2 = 1'b0; och2 = '0; ich2 = '0;
      cur_kernel = '0; cur_valid = 1'b0;
      #12;
      check("rst_kernel", kout, 72'd0);
      check("rst_valid", valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_addr", addr, 10'd0);
      check("rst_state", dstate, 2'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].rej) do_reject(vecs[v].o, vecs[v].i);
         else             do_load(vecs[v].o, vecs[v].i, vecs[v].base);
      end

      // req held for 20 edges: loads accepted at edges 0 and 12 only.
      @(negedge clk);
      req = 1'b1; och = 4'd4; ich = 4'd0;
      @(posedge clk);
      for (int c = 1; c <= 30; c++) begin
         logic e_rd, e_busy;
         @(negedge clk);
         if (c == 20) req = 1'b0;
         e_rd   = ((c >= 1) && (c <= 9)) || ((c >= 13) && (c <= 21));
         e_busy = ((c >= 1) && (c <= 11)) || ((c >= 13) && (c <= 23));
         check("hold_rd_en", rd_en, e_rd);
         check("hold_busy", busy, e_busy);
         check("hold_done", done, (c == 11) || (c == 23));
         check("hold_err", err, 1'b0);
         if (e_rd) check("hold_addr", addr, 10'(36 + ((c <= 9) ? c - 1 : c - 13)));
      end
      cur_kernel = mk_kernel(36);
      check("hold_kernel", kout, cur_kernel);

      // Reset in cycle 5 of a load abandons it; nothing partial survives.
      do_load(0, 0, 0);
      @(negedge clk);
      req = 1'b1; och = 4'd3; ich = 4'd0;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req = 1'b0;
      end
      check("pre_rst_kernel", kout, mk_kernel(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_kernel", kout, 72'd0);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_rd_en", rd_en, 1'b0);
      check("mid_rst_addr", addr, 10'd0);
      check("mid_rst_busy", busy, 1'b0);
      cur_kernel = '0; cur_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_busy", busy, 1'b0);
         check("post_rst_done", done, 1'b0);
         check("post_rst_kernel", kout, 72'd0);
      end
      do_load(1, 0, 9);

      // IN_CH=2 instance: och=3, ich=1 gives base 63; ich=2 is rejected.
      @(negedge clk);
      req2 = 1'b1; och2 = 4'd3; ich2 = 4'd1;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         req2 = 1'b0;
         check("ic2_rd_en", rd_en2, (c <= 9) ? 1'b1 : 1'b0);
         check("ic2_addr", addr2, (c <= 9) ? 10'(63 + c - 1) : 10'd0);
         check("ic2_done", done2, (c == 11) ? 1'b1 : 1'b0);
      end
      check("ic2_kernel", kout2, mk_kernel(63));
      check("ic2_valid", valid2, 1'b1);
      @(negedge clk);
      req2 = 1'b1; och2 = 4'd3; ich2 = 4'd2;
      @(posedge clk);
      @(negedge clk);
      req2 = 1'b0;
      check("ic2_rej_err", err2, 1'b1);
      check("ic2_rej_rd_en", rd_en2, 1'b0);
      check("ic2_rej_kernel", kout2, mk_kernel(63));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of one signed kernel weight.
REQ-002 Parameter K, default 3, kernel side; T = K*K taps per kernel.
REQ-003 Parameter OUT_CH, default 8, number of output channels held in weight memory.
REQ-004 Parameter IN_CH, default 1, number of input channels held in weight memory.
REQ-005 Parameter ADDR_W, default 10, weight memory address width; must satisfy 2^ADDR_W >= OUT_CH*IN_CH*T.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 req  input  1  load request, sampled only in IDLE.
REQ-009 och  input  4  output-channel index, sampled with req.
REQ-010 ich  input  4  input-channel index, sampled with req.
REQ-011 mem_rd_en  output  1  weight memory read strobe.
REQ-012 mem_addr  output  ADDR_W  weight memory read address.
REQ-013 mem_rdata  input  DATA_W  weight memory read data, valid exactly one cycle after mem_rd_en.
REQ-014 kernel_out  output  T*DATA_W  active kernel; tap i occupies bits [i*DATA_W +: DATA_W], tap 0 = memory word at base.
REQ-015 busy  output  1  high from the cycle after req acceptance until done.
REQ-016 done  output  1  one-cycle pulse when a new kernel is committed to kernel_out.
REQ-017 valid  output  1  kernel_out holds a committed kernel.
REQ-018 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-019 FSM states: IDLE, FETCH, DRAIN, COMMIT; from COMMIT, unconditional return to IDLE.
REQ-020 In IDLE with req=1 and och<OUT_CH and ich<IN_CH: latch base = (och*IN_CH + ich)*T, zero the tap counter, go to FETCH.
REQ-021 In IDLE with req=1 and an index out of range: pulse err on the next cycle, stay in IDLE, issue no read, leave kernel_out and valid unchanged.
REQ-022 In FETCH: assert mem_rd_en for exactly T consecutive cycles with mem_addr = base, base+1, ... base+T-1; go to DRAIN after the read of base+T-1 is issued.
REQ-023 Each mem_rdata word is written one cycle after its read into a shadow tap register at index (address - base); kernel_out is not disturbed during FETCH and DRAIN.
REQ-024 DRAIN lasts one cycle and captures the last word; then COMMIT.
REQ-025 In COMMIT: copy all T shadow taps into kernel_out in one edge, set valid=1, pulse done.
REQ-026 Latency: req sampled at edge 0 -> first mem_rd_en cycle 1 -> done and new kernel_out visible in cycle T+2; with K=3 that is cycle 11.
REQ-027 req is ignored while busy=1: no queuing and no err.
REQ-028 req=1 in the same cycle done=1 (state COMMIT) is ignored; a new request is accepted from IDLE on the following cycle at the earliest.
REQ-029 mem_rd_en=0 and mem_addr=0 outside FETCH.
REQ-030 Weights are passed bit-exact, with no sign or width conversion.
REQ-031 Tap counter width = ceil(log2(T+1)); no wrap inside a fetch.

Reset
REQ-032 rst=0 forces IDLE asynchronously: kernel_out=0, shadow taps=0, valid=0, busy=0, done=0, err=0, mem_rd_en=0, mem_addr=0, counter=0.
REQ-033 Reset during FETCH or DRAIN abandons the load; no partial kernel ever reaches kernel_out; after release, the next req starts a fresh load.

Verification
REQ-034 Defaults, memory word n = n: req with och=2, ich=0 -> addresses 18..26 in cycles 1..9; done in cycle 11; kernel_out taps = 18..26; valid=1.
REQ-035 Back-to-back loads (och=0, then och=7 once IDLE): kernel_out holds 0..8 until the second done, then 63..71, with no intermediate values.
REQ-036 req with och=8 -> err pulse on the next cycle; no mem_rd_en; kernel_out and valid unchanged.
REQ-037 req held high for 20 cycles -> exactly two loads (accepted cycles 0 and 12); busy=1 throughout each load.
REQ-038 rst low in cycle 5 of a load (previous kernel = 0..8) -> kernel_out=0 and valid=0 immediately; a later load of och=1 yields 9..17.
REQ-039 IN_CH=2, och=3, ich=1 -> base = 63; addresses 63..71 are read.
